// File: rtl/lc2k_pkg.sv
// lc2k_pkg: shared LC-2K opcodes, instruction field positions and fetch-state enum
package lc2k_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_NOR  = 3'b001;
    localparam logic [2:0] OP_LW   = 3'b010;
    localparam logic [2:0] OP_SW   = 3'b011;
    localparam logic [2:0] OP_BEQ  = 3'b100;
    localparam logic [2:0] OP_JALR = 3'b101;
    localparam logic [2:0] OP_HALT = 3'b110;
    localparam logic [2:0] OP_NOOP = 3'b111;

    localparam int OPCODE_HI = 24;
    localparam int OPCODE_LO = 22;
    localparam int REGA_HI   = 21;
    localparam int REGA_LO   = 19;
    localparam int REGB_HI   = 18;
    localparam int REGB_LO   = 16;
    localparam int DEST_HI   = 2;
    localparam int DEST_LO   = 0;
    localparam int OFFSET_HI = 15;
    localparam int OFFSET_LO = 0;

    typedef enum logic [1:0] {IDLE, FETCH, ISSUE, HALT} fetch_state_t;

    function automatic logic [2:0] get_opcode(input logic [31:0] word);
        return word[OPCODE_HI:OPCODE_LO];
    endfunction

endpackage

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetches LC-2K words from instruction memory and hands them to the decoder
module instr_fetch_unit
    import lc2k_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] instruction,
    output logic [2:0]  opcode,
    output logic [31:0] pcCurrent,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        halted,
    output logic [31:0] retired_count
);

    fetch_state_t state, state_d;
    logic [31:0]  pc, pc_d, next_pc, addr_d, instr_d, pcc_d, count_d;
    logic         req_d, valid_d, halted_d;

    assign opcode = get_opcode(instruction);

    // Next-state and next-output logic; every output is registered so it is computed here one cycle ahead
    always_comb begin
        state_d  = state;
        pc_d     = pc;
        req_d    = imem_req;
        addr_d   = imem_addr;
        valid_d  = inst_valid;
        instr_d  = instruction;
        pcc_d    = pcCurrent;
        halted_d = halted;
        count_d  = retired_count;
        next_pc  = redirect_valid ? redirect_pc : pc + 32'd1;
        case (state)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                    pc_d    = RESET_PC;
                    req_d   = 1'b1;
                    addr_d  = RESET_PC;
                end
            end
            FETCH: begin
                if (imem_ack) begin
                    state_d = ISSUE;
                    req_d   = 1'b0;
                    valid_d = 1'b1;
                    instr_d = imem_rdata;
                    pcc_d   = pc;
                end
            end
            ISSUE: begin
                if (inst_ready) begin
                    count_d = retired_count + 32'd1;
                    valid_d = 1'b0;
                    if (get_opcode(instruction) == OP_HALT) begin
                        state_d  = HALT;
                        halted_d = 1'b1;
                    end else begin
                        state_d = FETCH;
                        pc_d    = next_pc;
                        req_d   = 1'b1;
                        addr_d  = next_pc;
                    end
                end
            end
            default: ;
        endcase
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            pc            <= RESET_PC;
            imem_req      <= 1'b0;
            imem_addr     <= '0;
            inst_valid    <= 1'b0;
            instruction   <= '0;
            pcCurrent     <= '0;
            halted        <= 1'b0;
            retired_count <= '0;
        end else begin
            state         <= state_d;
            pc            <= pc_d;
            imem_req      <= req_d;
            imem_addr     <= addr_d;
            inst_valid    <= valid_d;
            instruction   <= instr_d;
            pcCurrent     <= pcc_d;
            halted        <= halted_d;
            retired_count <= count_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed vector table plus hand sequences for the fetch unit
module tb_instr_fetch_unit;

    localparam logic [31:0] W_ADD  = 32'h0000_0001;
    localparam logic [31:0] W_NOR  = 32'h0040_0002;
    localparam logic [31:0] W_HALT = 32'h0180_0003;
    localparam logic [31:0] W_BEQ  = 32'h0100_0004;
    localparam logic [31:0] W_ADD2 = 32'h0000_0007;
    localparam logic [31:0] W_NOOP = 32'h01C0_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        inst_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req, inst_valid, halted;
    logic [31:0] imem_addr, instruction, pcCurrent, retired_count;
    logic [2:0]  opcode;
    logic        imem_req_b, inst_valid_b, halted_b;
    logic [31:0] imem_addr_b, instruction_b, pcCurrent_b, retired_count_b;
    logic [2:0]  opcode_b;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .start(start),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .instruction(instruction), .opcode(opcode),
        .pcCurrent(pcCurrent), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halted(halted), .retired_count(retired_count)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFF)) dut_b (
        .clk(clk), .reset(reset), .start(start),
        .imem_req(imem_req_b), .imem_addr(imem_addr_b), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid_b), .inst_ready(inst_ready), .instruction(instruction_b), .opcode(opcode_b),
        .pcCurrent(pcCurrent_b), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halted(halted_b), .retired_count(retired_count_b)
    );

    typedef struct {
        logic        start, ack, ready;
        logic [31:0] rdata;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] instr, pcc;
        logic        halted;
        logic [31:0] rc;
    } vec_t;

    vec_t vt[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        start = 1'b0;
        imem_ack = 1'b0;
        inst_ready = 1'b0;
        redirect_valid = 1'b0;
        tick;
        reset = 1'b0;
        tick;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] word);
        for (int i = 0; i < 10 && imem_req !== 1'b1; i++) tick;
        chk("req_before_ack", {31'd0, imem_req}, 32'd1);
        tick;
        imem_ack = 1'b1;
        imem_rdata = word;
        tick;
        imem_ack = 1'b0;
        chk("valid_after_ack", {31'd0, inst_valid}, 32'd1);
    endtask

    task automatic accept(input logic rv, input logic [31:0] rpc);
        inst_ready = 1'b1;
        redirect_valid = rv;
        redirect_pc = rpc;
        tick;
        inst_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0BAD_0BAD;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        vt[0]  = '{1'b1, 1'b0, 1'b1, 32'h0,  1'b1, 32'd0, 1'b0, 32'h0,  32'd0, 1'b0, 32'd0};
        vt[1]  = '{1'b0, 1'b0, 1'b1, 32'h0,  1'b1, 32'd0, 1'b0, 32'h0,  32'd0, 1'b0, 32'd0};
        vt[2]  = '{1'b0, 1'b1, 1'b1, W_ADD,  1'b0, 32'd0, 1'b1, W_ADD,  32'd0, 1'b0, 32'd0};
        vt[3]  = '{1'b0, 1'b0, 1'b1, 32'h0,  1'b1, 32'd1, 1'b0, W_ADD,  32'd0, 1'b0, 32'd1};
        vt[4]  = '{1'b0, 1'b0, 1'b1, 32'h0,  1'b1, 32'd1, 1'b0, W_ADD,  32'd0, 1'b0, 32'd1};
        vt[5]  = '{1'b0, 1'b1, 1'b1, W_NOR,  1'b0, 32'd1, 1'b1, W_NOR,  32'd1, 1'b0, 32'd1};
        vt[6]  = '{1'b0, 1'b0, 1'b1, 32'h0,  1'b1, 32'd2, 1'b0, W_NOR,  32'd1, 1'b0, 32'd2};
        vt[7]  = '{1'b0, 1'b0, 1'b1, 32'h0,  1'b1, 32'd2, 1'b0, W_NOR,  32'd1, 1'b0, 32'd2};
        vt[8]  = '{1'b0, 1'b1, 1'b1, W_HALT, 1'b0, 32'd2, 1'b1, W_HALT, 32'd2, 1'b0, 32'd2};
        vt[9]  = '{1'b0, 1'b0, 1'b1, 32'h0,  1'b0, 32'd2, 1'b0, W_HALT, 32'd2, 1'b1, 32'd3};
        vt[10] = '{1'b1, 1'b1, 1'b1, W_NOR,  1'b0, 32'd2, 1'b0, W_HALT, 32'd2, 1'b1, 32'd3};

        tick;
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        chk("rst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_instr", instruction, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_count", retired_count, 32'd0);
        reset = 1'b0;
        tick;
        tick;
        chk("idle_no_req", {31'd0, imem_req}, 32'd0);

        for (int i = 0; i < 11; i++) begin
            start = vt[i].start;
            imem_ack = vt[i].ack;
            inst_ready = vt[i].ready;
            imem_rdata = vt[i].rdata;
            tick;
            chk($sformatf("v%0d_req", i), {31'd0, imem_req}, {31'd0, vt[i].req});
            chk($sformatf("v%0d_addr", i), imem_addr, vt[i].addr);
            chk($sformatf("v%0d_valid", i), {31'd0, inst_valid}, {31'd0, vt[i].valid});
            chk($sformatf("v%0d_instr", i), instruction, vt[i].instr);
            chk($sformatf("v%0d_opcode", i), {29'd0, opcode}, {29'd0, vt[i].instr[24:22]});
            chk($sformatf("v%0d_pcc", i), pcCurrent, vt[i].pcc);
            chk($sformatf("v%0d_halted", i), {31'd0, halted}, {31'd0, vt[i].halted});
            chk($sformatf("v%0d_count", i), retired_count, vt[i].rc);
        end
        start = 1'b0;
        imem_ack = 1'b0;
        inst_ready = 1'b0;

        do_reset;
        pulse_start;
        fetch(W_ADD);
        accept(1'b1, 32'd5);
        chk("redir5_addr", imem_addr, 32'd5);
        fetch(W_BEQ);
        chk("beq_pcc", pcCurrent, 32'd5);
        accept(1'b1, 32'd20);
        chk("beq_taken_addr", imem_addr, 32'd20);
        chk("beq_taken_req", {31'd0, imem_req}, 32'd1);

        do_reset;
        pulse_start;
        fetch(W_ADD);
        accept(1'b1, 32'd5);
        fetch(W_BEQ);
        accept(1'b0, 32'd99);
        chk("beq_nt_addr", imem_addr, 32'd6);
        fetch(W_ADD2);
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin
                start = 1'b1;
                imem_ack = 1'b1;
                imem_rdata = 32'hDEAD_BEEF;
            end
            tick;
            start = 1'b0;
            imem_ack = 1'b0;
            chk($sformatf("stall%0d_instr", i), instruction, W_ADD2);
            chk($sformatf("stall%0d_pcc", i), pcCurrent, 32'd6);
            chk($sformatf("stall%0d_req", i), {31'd0, imem_req}, 32'd0);
            chk($sformatf("stall%0d_valid", i), {31'd0, inst_valid}, 32'd1);
            chk($sformatf("stall%0d_count", i), retired_count, 32'd2);
        end
        accept(1'b0, 32'd0);
        chk("after_stall_addr", imem_addr, 32'd7);
        chk("after_stall_count", retired_count, 32'd3);
        fetch(W_HALT);
        accept(1'b1, 32'd50);
        chk("halt_halted", {31'd0, halted}, 32'd1);
        chk("halt_no_redirect", imem_addr, 32'd7);
        chk("halt_count", retired_count, 32'd4);
        start = 1'b1;
        imem_ack = 1'b1;
        tick;
        start = 1'b0;
        imem_ack = 1'b0;
        tick;
        chk("halt_abs_halted", {31'd0, halted}, 32'd1);
        chk("halt_abs_req", {31'd0, imem_req}, 32'd0);
        chk("halt_abs_valid", {31'd0, inst_valid}, 32'd0);
        chk("halt_abs_count", retired_count, 32'd4);

        do_reset;
        pulse_start;
        chk("wrap_start_addr", imem_addr_b, 32'hFFFF_FFFF);
        fetch(W_NOOP);
        accept(1'b0, 32'd0);
        chk("wrap_addr", imem_addr_b, 32'h0000_0000);
        chk("wrap_req", {31'd0, imem_req_b}, 32'd1);

        do_reset;
        pulse_start;
        chk("midfetch_req", {31'd0, imem_req}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_req", {31'd0, imem_req}, 32'd0);
        chk("async_rst_addr", imem_addr, 32'd0);
        reset = 1'b0;
        imem_ack = 1'b1;
        imem_rdata = W_ADD;
        tick;
        imem_ack = 1'b0;
        chk("stray_valid", {31'd0, inst_valid}, 32'd0);
        chk("stray_req", {31'd0, imem_req}, 32'd0);
        chk("stray_instr", instruction, 32'd0);
        chk("stray_opcode", {29'd0, opcode}, 32'd0);
        chk("stray_pcc", pcCurrent, 32'd0);
        chk("stray_halted", {31'd0, halted}, 32'd0);
        chk("stray_count", retired_count, 32'd0);
        tick;
        chk("stays_idle_req", {31'd0, imem_req}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
